// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width, register-address width and the
// multiply/writeback state encodings.
package cpu_defs;

    localparam int DATA_W   = 8;
    localparam int RA_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } mul_ops_t;

    // {zero, overflow} from the full multiplier result {carry, hi, lo}.
    function automatic logic [1:0] prod_flags(input logic [2*DATA_W:0] p);
        prod_flags = {(p == '0), (p[2*DATA_W:DATA_W] != '0)};
    endfunction

endpackage

// File: rtl/mul.sv
// Combinational 8x8 multiplier; carry is the bit above the 16-bit product
// and is always 0 for 8-bit operands.
module mul
    import cpu_defs::*;
(
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] out_lo,
    output logic [DATA_W-1:0] out_hi,
    output logic              carry
);

    logic [2*DATA_W:0] full;

    assign full = (2*DATA_W+1)'(in_a) * (2*DATA_W+1)'(in_b);
    assign {carry, out_hi, out_lo} = full;

endmodule

// File: rtl/mul_wb_ctrl.sv
// Multiply control stage: latches a request, registers the product of the
// shared multiplier and writes it back to the register file byte by byte.
module mul_wb_ctrl
    import cpu_defs::*;
#(
    parameter int RA_W       = RA_W_DEF,
    parameter bit HOLD_FLAGS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [RA_W-1:0]   dst_lo,
    input  logic [RA_W-1:0]   dst_hi,
    input  logic              hi_en,
    output logic              busy,
    output logic              done,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_z,
    output logic              flag_o
);

    state_t            state;
    mul_ops_t          ops_q;
    logic [RA_W-1:0]   dlo_q;
    logic [RA_W-1:0]   dhi_q;
    logic              hien_q;
    logic [DATA_W-1:0] prod_hi;

    logic [DATA_W-1:0] mul_lo;
    logic [DATA_W-1:0] mul_hi;
    logic              mul_c;

    mul u_mul (
        .in_a   (ops_q.a),
        .in_b   (ops_q.b),
        .out_lo (mul_lo),
        .out_hi (mul_hi),
        .carry  (mul_c)
    );

    // The low product byte goes straight into rf_wdata at the EXEC edge,
    // so only the high byte needs its own holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ops_q    <= '0;
            dlo_q    <= '0;
            dhi_q    <= '0;
            hien_q   <= 1'b0;
            prod_hi  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            flag_z   <= 1'b0;
            flag_o   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ops_q  <= '{a: op_a, b: op_b};
                        dlo_q  <= dst_lo;
                        dhi_q  <= dst_hi;
                        hien_q <= hi_en;
                        busy   <= 1'b1;
                        state  <= EXEC;
                        if (!HOLD_FLAGS) begin
                            flag_z <= 1'b0;
                            flag_o <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    prod_hi          <= mul_hi;
                    {flag_z, flag_o} <= prod_flags({mul_c, mul_hi, mul_lo});
                    rf_we            <= 1'b1;
                    rf_waddr         <= dlo_q;
                    rf_wdata         <= mul_lo;
                    state            <= WB_LO;
                end
                WB_LO: begin
                    if (hien_q) begin
                        rf_waddr <= dhi_q;
                        rf_wdata <= prod_hi;
                        state    <= WB_HI;
                    end else begin
                        rf_we <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                WB_HI: begin
                    rf_we <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_wb_ctrl.sv
// Directed bench for mul_wb_ctrl: expected register-file writes are queued
// at request time and popped as the DUT writes them back.
module tb_mul_wb_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] op_a, op_b;
    logic [2:0] dst_lo, dst_hi;
    logic       hi_en;
    logic       busy, done, rf_we, flag_z, flag_o;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    mul_wb_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .dst_lo   (dst_lo),
        .dst_hi   (dst_hi),
        .hi_en    (hi_en),
        .busy     (busy),
        .done     (done),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .flag_z   (flag_z),
        .flag_o   (flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed addr %0d data %0h expected no write",
                       rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", 32'(rf_waddr), 32'(mon_e.addr));
                check("wb_data", 32'(rf_wdata), 32'(mon_e.data));
            end
        end
    end

    task automatic drive_req(input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] dl, input logic [2:0] dh, input logic he);
        logic [15:0] p;
        p      = 16'(a) * 16'(b);
        start  = 1'b1;
        op_a   = a;
        op_b   = b;
        dst_lo = dl;
        dst_hi = dh;
        hi_en  = he;
        exp_q.push_back('{addr: dl, data: p[7:0]});
        if (he) exp_q.push_back('{addr: dh, data: p[15:8]});
    endtask

    // Full transaction with cycle-accurate checks; returns in the done cycle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] dl, input logic [2:0] dh, input logic he);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        @(negedge clk);
        drive_req(a, b, dl, dh, he);
        @(negedge clk);
        start = 1'b0;
        check("exec_busy", 32'(busy), 1);
        check("exec_we", 32'(rf_we), 0);
        @(negedge clk);
        check("wblo_we", 32'(rf_we), 1);
        check("wblo_busy", 32'(busy), 1);
        if (he) begin
            @(negedge clk);
            check("wbhi_we", 32'(rf_we), 1);
            check("wbhi_done", 32'(done), 0);
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_we", 32'(rf_we), 0);
        check("flag_z", 32'(flag_z), 32'(p == 16'h0));
        check("flag_o", 32'(flag_o), 32'(p[15:8] != 8'h0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
        dst_lo = '0; dst_hi = '0; hi_en = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_we", 32'(rf_we), 0);
        check("rst_waddr", 32'(rf_waddr), 0);
        check("rst_wdata", 32'(rf_wdata), 0);
        check("rst_flags", 32'({flag_z, flag_o}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h0F, 8'h11, 3'd2, 3'd3, 1'b1);
        @(negedge clk);
        check("done_once", 32'(done), 0);

        do_op(8'hFF, 8'hFF, 3'd4, 3'd5, 1'b1);
        do_op(8'h00, 8'h37, 3'd1, 3'd6, 1'b0);

        // Starts while busy must be ignored; a start in the done cycle is taken.
        @(negedge clk);
        drive_req(8'h05, 8'h06, 3'd4, 3'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; op_a = 8'h02; op_b = 8'h02;
            check("busy_ign", 32'(busy), 1);
        end
        @(negedge clk);
        check("b2b_done", 32'(done), 1);
        drive_req(8'h03, 8'h04, 3'd6, 3'd7, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        @(negedge clk);
        check("b2b_we", 32'(rf_we), 1);
        @(negedge clk);
        check("b2b_done2", 32'(done), 1);

        // Reset during WB_LO: the high-byte write must never appear.
        @(negedge clk);
        drive_req(8'h10, 8'h10, 3'd1, 3'd2, 1'b0);
        hi_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_we", 32'(rf_we), 1);
        check("pre_rst_o", 32'(flag_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(rf_we), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_flags", 32'({flag_z, flag_o}), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_rst_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        do_op(8'h07, 8'h09, 3'd3, 3'd3, 1'b1);

        // Flags hold through IDLE and update only at the next EXEC edge.
        do_op(8'hFF, 8'h02, 3'd0, 3'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_o", 32'(flag_o), 1);
        end
        @(negedge clk);
        drive_req(8'h01, 8'h01, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("exec_hold_o", 32'(flag_o), 1);
        @(negedge clk);
        check("upd_o", 32'(flag_o), 0);
        check("upd_z", 32'(flag_z), 0);
        @(negedge clk);
        check("last_done", 32'(done), 1);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
